rns11_tc_accum_ctrl: RTL
========================

Name: rns11_tc_accum_ctrl

Overview:
Sequencing controller for the modulo-11 thermometer-code (TC) datapath. It accepts a programmed number of 10-bit TC residue operands over a valid/ready handshake and accumulates them modulo 11. It then presents the result in both TC and 4-bit binary form over a second handshake. It sits between the RNS operand source and the binary back-end, and owns the single TC-to-binary decode path.

Parameters:
MOD, 11, residue modulus; fixed; any other value is unsupported.
TC_W, 10, TC width (MOD-1). Value v is encoded as v ones in the LSBs; 0 is all zeros.
BIN_W, 4, binary result width.
CNT_W, 8, width of the operand-count field.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
len  in  CNT_W  number of operands for the job; sampled with start
op_valid  in  1  operand valid
op_tc  in  TC_W  operand, TC encoded
op_ready  out  1  operand accepted when op_valid & op_ready
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_tc  out  TC_W  accumulated residue, TC encoded
res_bin  out  BIN_W  accumulated residue, binary 0..10
busy  out  1  high in any state other than IDLE
err  out  1  sticky invalid-code flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, acc=0, remaining count=0. All outputs 0: op_ready, res_valid, res_tc, res_bin, busy, err.
- Reset mid-job aborts the job immediately. No result is produced; an accepted partial sum is discarded.
- FSM states:
  - IDLE -> ACCUM when start=1 and len!=0. Action: acc<=0, cnt<=len.
  - IDLE -> OUT when start=1 and len==0. Action: acc<=0; the result is 0.
  - ACCUM -> OUT on acceptance of the operand with cnt==1.
  - OUT -> IDLE on res_valid & res_ready.
- start is ignored outside IDLE.
- op_ready=1 only in ACCUM, registered; it is 0 in the cycle after the last operand is accepted.
- On each accepted operand: acc <= (acc + dec(op_tc)) mod 11, cnt <= cnt-1.
  - Sum range is 0..20; subtract 11 when the sum is >=11.
  - dec() is the TC-to-binary decode. Any non-thermometer pattern decodes to 0.
- One operand is accepted per cycle maximum, with no bubbles while op_valid stays high.
- Latency: res_valid rises the cycle after the last operand is accepted. For len==0 it rises the cycle after start.
- res_tc and res_bin are registered, stable and held while res_valid=1 and res_ready=0. Both return to 0 on leaving OUT.
- res_bin = dec(res_tc) at all times. res_tc is always a valid TC code.
- Simultaneous res_ready and start in OUT: the result retires; start is ignored because the FSM is not yet in IDLE. A new start is accepted the next cycle.
- busy=1 in ACCUM and OUT.

Optional Feature:
Macro RNS11_TC_CHECK_EN.
- Defined:
  - Each accepted operand is checked for thermometer validity: ones contiguous from bit 0, no 1 above a 0.
  - On an invalid operand, err is set (sticky until reset). The operand still contributes 0 and the job completes normally.
- Undefined:
  - No checker logic; err is tied to 0.
  - Invalid operands still contribute 0.

Decomposition:
- Shared package rns11_pkg holds:
  - constants MOD=11, TC_W=10, BIN_W=4;
  - the FSM state enum (IDLE, ACCUM, OUT);
  - functions for TC encode (binary->TC) and modular add.
- One sub-module: rns11_tc_decode. It is combinational TC->binary with invalid->0, and is instantiated twice: operand path and result path.

Test Plan:
1. len=3; ops 0x01F(5), 0x07F(7), 0x1FF(9) back-to-back -> res_valid 1 cycle after third accept; res_bin=4'hA, res_tc=0x3FF.
2. len=2; ops 0x3FF(10), 0x001(1) -> res_bin=0, res_tc=0x000 (exact wrap to 0).
3. len=0 with start -> busy=1, res_valid next cycle with res_bin=0. Hold res_ready=0 for 5 cycles: outputs stable. res_ready=1 -> IDLE, busy=0.
4. len=4; ops 3,3,3,3 with op_valid toggling every other cycle -> exactly 4 accepts, res_bin=1 (12 mod 11). Pulse start during ACCUM -> ignored.
5. Macro defined: len=2; ops 0x005 (invalid), 0x00F(4) -> err=1, res_bin=4. Macro undefined: same stimulus gives err=0, res_bin=4.
6. rst_n=0 after 2 of 3 operands -> all outputs 0 next cycle. A new job len=1, op 0x03F(6) -> res_bin=6.

Source files
------------

// File: rtl/rns11_pkg.sv
// rns11_pkg: shared modulo-11 constants, FSM state type and TC helper functions
package rns11_pkg;

    localparam int MOD   = 11;
    localparam int TC_W  = 10;
    localparam int BIN_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    // Thermometer code: ones contiguous from bit 0 (all zeros is value 0)
    function automatic logic tc_valid(input logic [TC_W-1:0] tc);
        logic [TC_W:0] t;
        t = {1'b0, tc};
        return (t & (t + 1'b1)) == '0;
    endfunction

    // Binary 0..10 to TC
    function automatic logic [TC_W-1:0] tc_enc(input logic [BIN_W-1:0] bin);
        logic [TC_W:0] t;
        t = ({{TC_W{1'b0}}, 1'b1} << bin) - 1'b1;
        return t[TC_W-1:0];
    endfunction

    // (a + b) mod 11 for a, b in 0..10
    function automatic logic [BIN_W-1:0] mod_add(input logic [BIN_W-1:0] a, input logic [BIN_W-1:0] b);
        logic [BIN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= (BIN_W+1)'(MOD)) ? BIN_W'(s - (BIN_W+1)'(MOD)) : BIN_W'(s);
    endfunction

endpackage

// File: rtl/rns11_tc_decode.sv
// rns11_tc_decode: combinational TC to binary; non-thermometer patterns decode to 0
module rns11_tc_decode
    import rns11_pkg::*;
(
    input  logic [TC_W-1:0]  tc,
    output logic [BIN_W-1:0] bin
);

    logic [BIN_W-1:0] ones;

    // Count ones, then zero the result for invalid codes
    always_comb begin
        ones = '0;
        for (int i = 0; i < TC_W; i++) ones = ones + BIN_W'(tc[i]);
        bin = tc_valid(tc) ? ones : '0;
    end

endmodule

// File: rtl/rns11_tc_accum_ctrl.sv
// rns11_tc_accum_ctrl: modulo-11 TC accumulate controller; optional operand checker via RNS11_TC_CHECK_EN
module rns11_tc_accum_ctrl
    import rns11_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             op_valid,
    input  logic [TC_W-1:0]  op_tc,
    output logic             op_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [TC_W-1:0]  res_tc,
    output logic [BIN_W-1:0] res_bin,
    output logic             busy,
    output logic             err
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] acc, op_bin, sum;
    logic             accept;

    rns11_tc_decode u_op_dec  (.tc(op_tc),  .bin(op_bin));
    rns11_tc_decode u_res_dec (.tc(res_tc), .bin(res_bin));

    assign sum    = mod_add(acc, op_bin);
    assign accept = op_valid && op_ready;
    assign busy   = state != IDLE;

    // Job sequencing, accumulation and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_tc    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= '0;
                    if (len != '0) begin
                        cnt      <= len;
                        op_ready <= 1'b1;
                        state    <= ACCUM;
                    end else begin
                        res_valid <= 1'b1;
                        res_tc    <= '0;
                        state     <= OUT;
                    end
                end
                ACCUM: if (accept) begin
                    acc <= sum;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        op_ready  <= 1'b0;
                        res_valid <= 1'b1;
                        res_tc    <= tc_enc(sum);
                        state     <= OUT;
                    end
                end
                OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    res_tc    <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RNS11_TC_CHECK_EN
    // Sticky flag for any accepted non-thermometer operand
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else if (accept && !tc_valid(op_tc)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
